uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_rx_cfg.sv | 116 +++++++++++
 tb/tb_uart_rx_cfg.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with a one-word ready/valid holding register.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits.
module uart_rx_cfg #(
   parameter int CLOCK_RATE = 100000000,
   parameter int BAUD_HEDEF = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx_i,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_out,
   output logic                 rx_valid,
   output logic                 rx_done,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun_err
);
   localparam int DIV = CLOCK_RATE / (BAUD_HEDEF * OVERSAMPLE);
   localparam int DW  = $clog2(DIV + 1);
   localparam int TW  = $clog2(OVERSAMPLE + 1);
   localparam int BW  = $clog2(DATA_BITS + 1);
   localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} state_t;
   localparam state_t S_AFTER_DATA = S_PARITY;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;
   localparam state_t S_AFTER_DATA = S_STOP;
`endif

   state_t               r_state, w_next;
   logic [1:0]           r_sync;
   logic [DW-1:0]        r_div;
   logic [TW-1:0]        r_tcnt;
   logic [BW-1:0]        r_bcnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_ferr;
   logic                 w_rx, w_tick, w_sample, w_last_stop, w_halt;

   assign w_rx        = r_sync[1];
   assign w_halt      = (r_state == S_IDLE) || (r_state == S_WAIT_HIGH);
   assign w_tick      = (r_div == DIV_LAST);
   assign w_sample    = w_tick && (r_tcnt == ((r_state == S_START) ? HALF_LAST : FULL_LAST));
   assign w_last_stop = (r_state == S_STOP) && w_sample && (r_bcnt == STOP_LAST);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      w_next = w_rx ? S_IDLE : S_START;
         S_START:     w_next = !w_sample ? S_START : (w_rx ? S_IDLE : S_DATA);
         S_DATA:      w_next = (w_sample && r_bcnt == DATA_LAST) ? S_AFTER_DATA : S_DATA;
`ifdef UART_RX_PARITY_EN
         S_PARITY:    w_next = w_sample ? S_STOP : S_PARITY;
`endif
         S_STOP:      w_next = !w_last_stop ? S_STOP : ((r_ferr || !w_rx) ? S_WAIT_HIGH : S_IDLE);
         S_WAIT_HIGH: w_next = w_rx ? S_IDLE : S_WAIT_HIGH;
         default:     w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_sync      <= 2'b11;
         r_div       <= '0;
         r_tcnt      <= '0;
         r_bcnt      <= '0;
         r_shift     <= '0;
         r_ferr      <= 1'b0;
         rx_out      <= '0;
         rx_valid    <= 1'b0;
         rx_done     <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         r_sync      <= {r_sync[0], rx_i};
         // Divider held at 0 while idle so the first tick is phase-locked to the start edge
         r_div       <= (w_halt || w_tick) ? '0 : r_div + 1'b1;
         r_tcnt      <= (w_halt || w_sample) ? '0 : (w_tick ? r_tcnt + 1'b1 : r_tcnt);
         r_bcnt      <= (r_state != w_next) ? '0 : (w_sample ? r_bcnt + 1'b1 : r_bcnt);
         r_shift     <= (r_state == S_DATA && w_sample) ? {w_rx, r_shift[DATA_BITS-1:1]} : r_shift;
         r_ferr      <= (r_state == S_START) ? 1'b0 : ((r_state == S_STOP && w_sample && !w_rx) ? 1'b1 : r_ferr);
         rx_done     <= w_last_stop;
         frame_err   <= w_last_stop ? (r_ferr || !w_rx) : frame_err;
         overrun_err <= w_last_stop && rx_valid && !rx_ready;
         rx_out      <= (w_last_stop && (!rx_valid || rx_ready)) ? r_shift : rx_out;
         rx_valid    <= w_last_stop ? 1'b1 : (rx_ready ? 1'b0 : rx_valid);
      end

`ifdef UART_RX_PARITY_EN
   logic r_par;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_par      <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         r_par      <= (r_state == S_START) ? 1'b0 :
                       ((w_sample && (r_state == S_DATA || r_state == S_PARITY)) ? r_par ^ w_rx : r_par);
         parity_err <= w_last_stop ? (r_par != 1'(PARITY_ODD)) : parity_err;
      end
`else
   assign parity_err = 1'b0 & 1'(PARITY_ODD);
`endif
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench for uart_rx_cfg at default parameters (864 clk per bit).
module tb_uart_rx_cfg;
   localparam int BIT = (100000000 / (115200 * 16)) * 16;

   typedef struct packed {
      logic [7:0] d;
      logic       fe;
      logic       pe;
      logic       ov;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_i = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_out;
   logic       rx_valid, rx_done, frame_err, parity_err, overrun_err;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   done_cnt = 0;
   int   ovr_cnt = 0;

   uart_rx_cfg dut (
      .clk(clk), .rst_n(rst_n), .rx_i(rx_i), .rx_ready(rx_ready),
      .rx_out(rx_out), .rx_valid(rx_valid), .rx_done(rx_done),
      .frame_err(frame_err), .parity_err(parity_err), .overrun_err(overrun_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (overrun_err) ovr_cnt++;
      if (rx_done) begin
         exp_t e;
         done_cnt++;
         if (q.size() == 0) check("unexpected_done", 1, 0);
         else begin
            e = q.pop_front();
            check("rx_out", rx_out, e.d);
            check("frame_err", frame_err, e.fe);
            check("parity_err", parity_err, e.pe);
            check("overrun_err", overrun_err, e.ov);
            check("rx_valid_at_done", rx_valid, 1);
         end
      end
   end

   task automatic hold(input logic v, input int n);
      rx_i = v;
      repeat (n) @(posedge clk);
   endtask

   task automatic send(input logic [7:0] d, input logic par, input logic stop);
      hold(1'b0, BIT);
      for (int i = 0; i < 8; i++) hold(d[i], BIT);
`ifdef UART_RX_PARITY_EN
      hold(par, BIT);
`else
      if (par) rx_i = 1'b1;
`endif
      hold(stop, BIT);
      rx_i = 1'b1;
   endtask

   task automatic consume();
      @(posedge clk);
      #1 rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
      check("valid_cleared", rx_valid, 0);
   endtask

   task automatic frame(input logic [7:0] d, input logic par, input logic pe);
      q.push_back('{d: d, fe: 1'b0, pe: pe, ov: 1'b0});
      send(d, par, 1'b1);
      hold(1'b1, BIT / 2);
   endtask

   initial begin
      int base;
      repeat (5) @(posedge clk);
      #1;
      check("rst_rx_out", rx_out, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_done", rx_done, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_parity_err", parity_err, 0);
      check("rst_overrun", overrun_err, 0);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);

      frame(8'h55, 1'b0, 1'b0);
      check("done_cnt_55", done_cnt, 1);
      check("valid_55", rx_valid, 1);
      check("out_55", rx_out, 8'h55);
      consume();

      base = done_cnt;
      hold(1'b0, 200);
      hold(1'b1, BIT);
      check("false_start_no_done", done_cnt, base);
      frame(8'h3C, 1'b0, 1'b0);
      check("out_3c", rx_out, 8'h3C);
      consume();

      base = done_cnt;
      q.push_back('{d: 8'hA3, fe: 1'b1, pe: 1'b0, ov: 1'b0});
      send(8'hA3, 1'b0, 1'b0);
      hold(1'b0, 2 * BIT);
      check("ferr_one_done", done_cnt, base + 1);
      check("ferr_held", frame_err, 1);
      hold(1'b1, BIT);
      check("ferr_out_a3", rx_out, 8'hA3);
      consume();

      base = ovr_cnt;
      frame(8'h11, 1'b0, 1'b0);
      q.push_back('{d: 8'h11, fe: 1'b0, pe: 1'b0, ov: 1'b1});
      send(8'h22, 1'b0, 1'b1);
      hold(1'b1, BIT / 2);
      check("ovr_out_kept", rx_out, 8'h11);
      check("ovr_pulses", ovr_cnt, base + 1);
      consume();

`ifdef UART_RX_PARITY_EN
      frame(8'h07, 1'b0, 1'b1);
      check("par_bad", parity_err, 1);
      consume();
      frame(8'h07, 1'b1, 1'b0);
      check("par_good", parity_err, 0);
      consume();
`endif

      base = done_cnt;
      hold(1'b0, BIT);
      for (int i = 0; i < 4; i++) hold(1'b0, BIT);
      hold(1'b1, BIT / 2);
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mid_rst_valid", rx_valid, 0);
      check("mid_rst_out", rx_out, 0);
      check("mid_rst_ferr", frame_err, 0);
      rst_n = 1'b1;
      hold(1'b1, 2 * BIT);
      check("mid_rst_no_done", done_cnt, base);
      check("mid_rst_valid_after", rx_valid, 0);
      frame(8'h0F, 1'b0, 1'b0);
      check("out_0f", rx_out, 8'h0F);
      check("done_after_rst", done_cnt, base + 1);
      check("sb_empty", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
